// File: rtl/gray_codec_if.sv
// rtl/gray_codec_if.sv - request/result handshake bundle for the Gray codec
interface gray_codec_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/gray_codec.sv
// rtl/gray_codec.sv - one-cycle Gray encode/decode/increment unit with valid/ready handshake
module gray_codec #(
  parameter int WIDTH      = 4,
  parameter int CHECK_MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  gray_codec_if.slave  bus
);

  localparam logic [1:0] MODE_B2G = 2'b00;
  localparam logic [1:0] MODE_G2B = 2'b01;
  localparam logic [1:0] MODE_INC = 2'b10;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_err_q,   out_err_d;
  logic [WIDTH-1:0] result;
  logic             result_err;
  logic             accept;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The output slot frees up either when empty or when it is drained this cycle.
  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // Operation decode; the increment wraps naturally in WIDTH-bit arithmetic.
  always_comb begin
    result     = bus.in_data;
    result_err = 1'b0;
    case (bus.in_mode)
      MODE_B2G: result = bin2gray(bus.in_data);
      MODE_G2B: result = gray2bin(bus.in_data);
      MODE_INC: result = bin2gray(gray2bin(bus.in_data) + WIDTH'(1));
      default: begin
        result     = bus.in_data;
        result_err = (CHECK_MODE != 0);
      end
    endcase
  end

  // Next state of the output register: load on accept, drop valid on a bare consume.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_err_d   = result_err;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset that also discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_gray_codec.sv
// tb/tb_gray_codec.sv - scoreboard bench for gray_codec with a table-based Gray model
module tb_gray_codec;

  typedef struct {
    logic [3:0] d;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   rnd_ready = 1'b0;
  exp_t q[$];
  int   gseq[16];

  gray_codec_if #(.WIDTH(4)) bus ();

  gray_codec #(.WIDTH(4), .CHECK_MODE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reflected Gray sequence: position n holds the Gray code of n.
  task automatic build_table();
    int size;
    gseq[0] = 0;
    size = 1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < size; i++) gseq[size + i] = gseq[size - 1 - i] | (1 << k);
      size = size * 2;
    end
  endtask

  function automatic int g_index(input int g);
    for (int i = 0; i < 16; i++) if (gseq[i] == g) return i;
    return 0;
  endfunction

  function automatic exp_t model(input logic [1:0] m, input logic [3:0] d);
    exp_t r;
    r.e = 1'b0;
    case (m)
      2'd0: r.d = 4'(gseq[d]);
      2'd1: r.d = 4'(g_index(int'(d)));
      2'd2: r.d = 4'(gseq[(g_index(int'(d)) + 1) % 16]);
      default: begin
        r.d = d;
        r.e = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic push(input logic [1:0] m, input logic [3:0] d, input bit use_exp,
                      input logic [3:0] ed, input logic ee);
    exp_t r;
    if (use_exp) begin
      r.d = ed;
      r.e = ee;
    end else begin
      r = model(m, d);
    end
    q.push_back(r);
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] d, input bit use_exp,
                      input logic [3:0] ed, input logic ee);
    bit done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_mode  = m;
      bus.in_data  = d;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.in_ready) begin
        push(m, d, use_exp, ed, ee);
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_mode  = 2'($urandom);
      bus.in_data  = 4'($urandom);
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: samples after the driver settles, pops expectations on each consume.
  initial begin
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, prev_acc = 1'b0;
    logic [3:0] prev_data = '0;
    logic       prev_err = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        q.delete();
      end else begin
        chk("in_ready", bus.in_ready, (!bus.out_valid || bus.out_ready));
        if (prev_acc) chk("latency_valid", bus.out_valid, 1);
        if (!prev_rst && prev_valid && !prev_ready) begin
          chk("hold_valid", bus.out_valid, prev_valid);
          chk("hold_data", bus.out_data, prev_data);
          chk("hold_err", bus.out_err, prev_err);
        end
        if (!prev_rst && prev_valid && prev_ready && !prev_acc) begin
          chk("drain_valid", bus.out_valid, 0);
          chk("drain_keep_data", bus.out_data, prev_data);
        end
        if (bus.out_valid === 1'b1) begin
          if (q.size() == 0) begin
            chk("stale_output", 1, 0);
          end else if (bus.out_ready) begin
            e = q.pop_front();
            chk("out_data", bus.out_data, e.d);
            chk("out_err", bus.out_err, e.e);
          end
        end
      end
      prev_acc   = bus.in_valid && bus.in_ready;
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
      prev_err   = bus.out_err;
      prev_rst   = rst;
    end
  end

  initial begin
    build_table();
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b00;
    bus.in_data   = 4'hA;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_data", bus.out_data, 0);
    chk("reset_err", bus.out_err, 0);
    chk("reset_in_ready", bus.in_ready, 0);

    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'b00;
    bus.in_data  = 4'b0011;
    #1;
    chk("first_accept", bus.in_ready, 1);
    if (bus.in_ready) push(2'b00, 4'b0011, 1'b1, 4'b0010, 1'b0);

    send(2'b00, 4'b1010, 1'b1, 4'b1111, 1'b0);
    send(2'b01, 4'b1000, 1'b1, 4'b1111, 1'b0);
    for (int v = 0; v < 16; v++) send(2'b00, 4'(v), 1'b0, 4'h0, 1'b0);
    for (int v = 0; v < 16; v++) send(2'b01, 4'(v), 1'b0, 4'h0, 1'b0);
    for (int v = 0; v < 16; v++) send(2'b01, 4'(gseq[v]), 1'b1, 4'(v), 1'b0);

    send(2'b10, 4'b0110, 1'b1, 4'b0111, 1'b0);
    send(2'b10, 4'b1000, 1'b1, 4'b0000, 1'b0);
    send(2'b11, 4'b0101, 1'b1, 4'b0101, 1'b1);
    send(2'b00, 4'b0101, 1'b1, 4'b0111, 1'b0);
    idle(2);

    send(2'b00, 4'd6, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b00;
    bus.in_data   = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_low", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_accept", bus.in_ready, 1);
    if (bus.in_ready) push(2'b00, 4'd9, 1'b0, 4'h0, 1'b0);
    send(2'b01, 4'd9, 1'b0, 4'h0, 1'b0);
    send(2'b10, 4'd3, 1'b0, 4'h0, 1'b0);
    idle(2);

    send(2'b00, 4'd12, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd5;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midreset_valid", bus.out_valid, 0);
    chk("midreset_data", bus.out_data, 0);
    chk("midreset_err", bus.out_err, 0);
    bus.out_ready = 1'b1;
    idle(3);

    rnd_ready = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(2'($urandom), 4'($urandom), 1'b0, 4'h0, 1'b0);
    end
    rnd_ready = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    #3;
    chk("drain_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
